// File: rtl/dcache_mshr_pkg.sv
// Shared memory-interface types and MSHR entry definitions for the dcache miss tracker.
package dcache_mshr_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned BLOCK_W      = 64;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned NUM_MSHR_DEF = 4;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef struct packed {
    logic     valid;
    ADDR      addr;
    MEM_BLOCK data;
    logic     prior;
  } MEM_REQ_PACKET;

  typedef struct packed {
    MEM_BLOCK data;
    MEM_TAG   mem_tag;
  } MEM_DATA_PACKET;

  typedef enum logic [1:0] {
    MSHR_INVALID   = 2'd0,
    MSHR_PEND_REQ  = 2'd1,
    MSHR_WAIT_DATA = 2'd2
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE state;
    ADDR       addr;
    logic      is_wb;
    MEM_BLOCK  data;
    MEM_TAG    tag;
  } MSHR_ENTRY;

endpackage

// File: rtl/dcache_mshr_psel_lowest.sv
// Lowest-index priority selector: returns the index of the lowest set request bit.
module dcache_mshr_psel_lowest #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_mshr.sv
// Miss-status holding registers: tracks dcache fills and writebacks, issues one memory
// request per cycle, matches returning tags and delivers completed fills.
module dcache_mshr
  import dcache_mshr_pkg::*;
#(
  parameter int unsigned NUM_MSHR = NUM_MSHR_DEF,
  parameter int unsigned IDX_W    = $clog2(NUM_MSHR)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           miss_valid,
  input  ADDR            miss_addr,
  input  logic           miss_is_wb,
  input  MEM_BLOCK       miss_data,
  output logic           miss_accepted,
  output logic [IDX_W-1:0] miss_idx,
  output logic           mshr_full,
  output MEM_REQ_PACKET  dcache_mem_req_packet,
  input  logic           dcache_mem_req_accepted,
  input  MEM_TAG         mem_trxn_tag,
  input  MEM_DATA_PACKET mem_data_packet,
  output logic           fill_valid,
  output logic [IDX_W-1:0] fill_idx,
  output ADDR            fill_addr,
  output MEM_BLOCK       fill_data
);

  MSHR_ENTRY entries   [NUM_MSHR];
  MSHR_ENTRY entries_n [NUM_MSHR];

  logic [NUM_MSHR-1:0] free_v, pend_ld, pend_wb, ld_hit, wb_block, tag_hit;
  logic [IDX_W-1:0]    free_idx, ld_idx, wb_idx, hit_idx, fill_sel, iss_idx;
  logic                free_any, ld_any, wb_any, hit_any, fill_any, iss_any, do_alloc;
  ADDR                 miss_blk;

  assign miss_blk = miss_addr & ~ADDR'(7);

  // Per-entry status vectors, all from registered state.
  always_comb begin
    for (int i = 0; i < int'(NUM_MSHR); i++) begin
      free_v[i]   = entries[i].state == MSHR_INVALID;
      pend_ld[i]  = entries[i].state == MSHR_PEND_REQ && !entries[i].is_wb;
      pend_wb[i]  = entries[i].state == MSHR_PEND_REQ && entries[i].is_wb;
      ld_hit[i]   = entries[i].state != MSHR_INVALID && !entries[i].is_wb &&
                    entries[i].addr == miss_blk;
      wb_block[i] = pend_wb[i] && entries[i].addr == miss_blk;
      tag_hit[i]  = entries[i].state == MSHR_WAIT_DATA && mem_data_packet.mem_tag != '0 &&
                    entries[i].tag == mem_data_packet.mem_tag;
    end
  end

  dcache_mshr_psel_lowest #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_free (.req(free_v),  .idx(free_idx), .any(free_any));
  dcache_mshr_psel_lowest #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_ld   (.req(pend_ld), .idx(ld_idx),   .any(ld_any));
  dcache_mshr_psel_lowest #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_wb   (.req(pend_wb), .idx(wb_idx),   .any(wb_any));
  dcache_mshr_psel_lowest #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_hit  (.req(ld_hit),  .idx(hit_idx),  .any(hit_any));
  dcache_mshr_psel_lowest #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_fill (.req(tag_hit), .idx(fill_sel), .any(fill_any));

  assign mshr_full = ~free_any;
  assign iss_any   = ld_any | wb_any;
  assign iss_idx   = ld_any ? ld_idx : wb_idx;

  // Load merge beats allocation; a load to a still-pending writeback block must wait.
  always_comb begin
    miss_accepted = 1'b0;
    miss_idx      = '0;
    do_alloc      = 1'b0;
    if (miss_valid) begin
      if (!miss_is_wb && hit_any) begin
        miss_accepted = 1'b1;
        miss_idx      = hit_idx;
      end else if (!miss_is_wb && (|wb_block)) begin
        miss_accepted = 1'b0;
      end else if (free_any) begin
        miss_accepted = 1'b1;
        miss_idx      = free_idx;
        do_alloc      = 1'b1;
      end
    end
  end

  always_comb begin
    dcache_mem_req_packet = '0;
    if (iss_any) begin
      dcache_mem_req_packet.valid = 1'b1;
      dcache_mem_req_packet.addr  = entries[iss_idx].addr;
      dcache_mem_req_packet.data  = entries[iss_idx].data;
      dcache_mem_req_packet.prior = ~entries[iss_idx].is_wb;
    end
  end

  // Grant, data return and allocation touch disjoint entries, so all apply together.
  always_comb begin
    entries_n = entries;
    if (iss_any && dcache_mem_req_accepted) begin
      if (entries[iss_idx].is_wb) begin
        entries_n[iss_idx].state = MSHR_INVALID;
      end else if (mem_trxn_tag != '0) begin
        entries_n[iss_idx].state = MSHR_WAIT_DATA;
        entries_n[iss_idx].tag   = mem_trxn_tag;
      end
    end
    if (fill_any) begin
      entries_n[fill_sel].state = MSHR_INVALID;
    end
    if (do_alloc) begin
      entries_n[free_idx].state = MSHR_PEND_REQ;
      entries_n[free_idx].addr  = miss_blk;
      entries_n[free_idx].is_wb = miss_is_wb;
      entries_n[free_idx].data  = miss_is_wb ? miss_data : '0;
      entries_n[free_idx].tag   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_MSHR); i++) begin
        entries[i] <= '0;
      end
    end else begin
      entries <= entries_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else begin
      fill_valid <= fill_any;
      if (fill_any) begin
        fill_idx  <= fill_sel;
        fill_addr <= entries[fill_sel].addr;
        fill_data <= mem_data_packet.data;
      end
    end
  end

  a_one_tag_hit: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(tag_hit));
  a_acc_valid:   assert property (@(posedge clock) disable iff (!reset_n) miss_accepted |-> miss_valid);

endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
- Miss-status holding register file between the dcache and the memory arbiter.
- Tracks outstanding dcache line fills and dirty writebacks, and presents at most one MEM_REQ_PACKET per cycle to the arbiter.
- Captures the memory transaction tag when a load is accepted, then matches returning data tags and delivers completed fills to the dcache.
- Merges a new load miss into an existing entry for the same block.

Parameters:
- NUM_MSHR, 4: number of tracking entries (power of 2, at least 2).
- IDX_W, $clog2(NUM_MSHR): entry index width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  dcache presents a miss/writeback request.
- miss_addr  in  ADDR  block-aligned address (low 3 bits ignored, treated as 0).
- miss_is_wb  in  1  1 = dirty writeback, 0 = load fill.
- miss_data  in  MEM_BLOCK  writeback data (ignored for loads).
- miss_accepted  out  1  request taken this cycle (combinational).
- miss_idx  out  IDX_W  entry allocated or merged into; valid only when miss_accepted.
- mshr_full  out  1  no INVALID entry (registered state).
- dcache_mem_req_packet  out  MEM_REQ_PACKET  request to the arbiter.
- dcache_mem_req_accepted  in  1  arbiter grant (same cycle).
- mem_trxn_tag  in  MEM_TAG  memory transaction tag for the granted request; 0 = rejected.
- mem_data_packet  in  MEM_DATA_PACKET  returning data and tag; tag 0 = none.
- fill_valid  out  1  registered one-cycle fill pulse.
- fill_idx  out  IDX_W  entry completing.
- fill_addr  out  ADDR  block address of the fill.
- fill_data  out  MEM_BLOCK  fill data.

Behaviour:
- Per-entry state: INVALID, PEND_REQ, WAIT_DATA.
- Per-entry fields: addr, is_wb, data, tag.
- Reset (asynchronous, reset_n=0):
  - All entries INVALID; tags 0.
  - fill_valid=0, fill_idx=0, fill_addr=0, fill_data=0.
  - dcache_mem_req_packet.valid=0.
  - Reset mid-transaction drops every outstanding entry; a late data tag after reset matches nothing and is ignored.
- Allocate (miss_valid=1), evaluated in priority order:
  - Load whose addr matches a non-INVALID load entry: merge, no allocation; miss_accepted=1, miss_idx = matching entry.
  - Load whose addr matches a PEND_REQ writeback: miss_accepted=0. The dcache retries until the writeback has issued, which preserves memory ordering.
  - Otherwise, if an INVALID entry exists: allocate the lowest-index INVALID entry to PEND_REQ next cycle; miss_accepted=1.
  - Else miss_accepted=0.
  - Writebacks never merge. A writeback matching an existing writeback is allocated as a separate entry.
- Issue (combinational from registered state):
  - Select the lowest-index PEND_REQ load. If none, select the lowest-index PEND_REQ writeback.
  - Packet fields: valid=1, addr, data, prior = 1 for load / 0 for writeback.
  - No PEND_REQ entry: valid=0 and all other fields 0.
  - An entry allocated in cycle N is first issuable in cycle N+1.
- Grant, when dcache_mem_req_accepted=1 for the selected entry:
  - Writeback: entry -> INVALID. The tag is ignored; stores return no data.
  - Load with mem_trxn_tag != 0: entry -> WAIT_DATA, tag captured.
  - Load with mem_trxn_tag == 0: entry stays PEND_REQ and retries next cycle.
  - No grant: packet held unchanged.
- Data return:
  - If mem_data_packet.mem_tag != 0 and equals the tag of a WAIT_DATA entry: next cycle fill_valid=1 with that entry's idx/addr and the data; entry -> INVALID.
  - Tag matching nothing: ignored.
  - Tags are unique among outstanding entries; at most one match.
- Simultaneous events:
  - Grant, data return, and allocation in one cycle all take effect.
  - An entry freed in cycle N is not reallocatable until N+1; full and free are computed from registered state.
  - A data tag equal to the tag captured in the same cycle is impossible and is not handled.
- Merge onto a WAIT_DATA entry in the same cycle as its data return: merge succeeds and the requester receives that fill.
- Assertions: at most one match on data tag; miss_accepted implies miss_valid.

Decomposition:
- Shared package (sys_defs.svh):
  - MSHR_STATE enum {MSHR_INVALID, MSHR_PEND_REQ, MSHR_WAIT_DATA}.
  - MSHR_ENTRY struct {state, addr, is_wb, data, tag}.
  - NUM_MSHR default.
  - MEM_REQ_PACKET, MEM_DATA_PACKET, MEM_TAG, MEM_BLOCK, ADDR already live there.
- One natural sub-module: psel_lowest (parameterised lowest-index priority selector). Used for free-entry select, load issue select, and writeback issue select.

Test Plan:
- Reset then load miss 0x1000: packet valid, prior=1, addr=0x1000 next cycle. Grant with tag 3; data tag 3 data 0xDEAD two cycles later -> fill_valid with idx 0, addr 0x1000, data 0xDEAD one cycle after; entry INVALID.
- Load granted with mem_trxn_tag=0: request re-presented next cycle unchanged. Second grant with tag 5 -> WAIT_DATA.
- Writeback 0x2000 and load 0x3000 both pending: load issued first. Writeback issued the following cycle, then freed on grant with no fill.
- Fill NUM_MSHR=4 entries: mshr_full=1, new miss -> miss_accepted=0. Data return frees an entry: miss still rejected that cycle, accepted the next.
- Second load to 0x1000 while entry 0 is WAIT_DATA: miss_accepted=1, miss_idx=0, no new packet. Load to an address with a PEND_REQ writeback -> rejected until the writeback grant.
- Deassert reset_n asynchronously while two entries are in WAIT_DATA: all outputs 0 immediately. Later data tag ignored; fill_valid stays 0.
